bram_block_scanner: RTL and testbench

//  Downstream consumer of the 1024x8 dual-port sample BRAM. On start, streams a block of

---
 rtl/bram_block_scanner.sv | 131 +++++++++++++
 tb/tb_bram_block_scanner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_block_scanner.sv
// Streams a block of signed samples from BRAM port A and reduces them to sum/min/max/count.
// Optional BRAM_SCAN_CLEAR_EN: zero each scanned word through port B right after it is read.
module bram_block_scanner #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we,
    output logic [DATA_W-1:0] clr_data,
    output logic [ACC_W-1:0]  sum,
    output logic [DATA_W-1:0] min_val,
    output logic [DATA_W-1:0] max_val,
    output logic [ADDR_W:0]   count
);

    // state | meaning
    // IDLE  | waiting for start, results held
    // ISSUE | one read address per cycle, base..base+L-1
    // DRAIN | last read in flight, final sample captured at end of cycle
    // DONE  | done pulse, results valid
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [ADDR_W:0]   LEN_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t            state;
    logic [ADDR_W-1:0] issue_left;
    logic              issue_q;
    logic [ADDR_W:0]   len_m1;
    logic [ACC_W-1:0]  sample_ext;

    assign len_m1     = length - LEN_ONE;
    assign sample_ext = {{(ACC_W-DATA_W){rd_data[DATA_W-1]}}, rd_data};
    assign clr_data   = '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_addr    <= '0;
            issue_left <= '0;
            issue_q    <= 1'b0;
            sum        <= '0;
            min_val    <= '0;
            max_val    <= '0;
            count      <= '0;
        end else begin
            done    <= 1'b0;
            issue_q <= 1'b0;

            // issue_q marks the cycle in which rd_data holds a requested sample
            if (issue_q) begin
                sum   <= sum + sample_ext;
                count <= count + LEN_ONE;
                if (count == '0) begin
                    min_val <= rd_data;
                    max_val <= rd_data;
                end else begin
                    if ($signed(rd_data) < $signed(min_val)) min_val <= rd_data;
                    if ($signed(rd_data) > $signed(max_val)) max_val <= rd_data;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        sum     <= '0;
                        min_val <= '0;
                        max_val <= '0;
                        count   <= '0;
                        if (length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            rd_addr    <= base_addr;
                            issue_left <= len_m1[ADDR_W-1:0];
                        end
                    end
                end
                ISSUE: begin
                    issue_q <= 1'b1;
                    if (issue_left == '0) begin
                        state <= DRAIN;
                    end else begin
                        rd_addr    <= rd_addr + ADDR_ONE;
                        issue_left <= issue_left - ADDR_ONE;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRAM_SCAN_CLEAR_EN
    logic [ADDR_W-1:0] cap_addr;

    // Clear trails the read by one cycle so port A has already captured the word.
    always_ff @(posedge clk) begin
        if (!rst) cap_addr <= '0;
        else      cap_addr <= rd_addr;
    end

    assign clr_we   = issue_q;
    assign clr_addr = cap_addr;
`else
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

endmodule

// File: tb/tb_bram_block_scanner.sv
// Directed bench for bram_block_scanner with a behavioural 1024x8 dual-port BRAM and a result scoreboard.
module tb_bram_block_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] length = '0;
    logic        busy, done, clr_we;
    logic [9:0]  rd_addr, clr_addr;
    logic [7:0]  rd_data = '0;
    logic [7:0]  clr_data, min_val, max_val;
    logic [17:0] sum;
    logic [10:0] count;

    logic [7:0]  mem [0:1023];
    logic        wr_en = 1'b0;
    logic [9:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [17:0] sum;
        logic [7:0]  mn;
        logic [7:0]  mx;
        logic [10:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] addr_q[$];

    bram_block_scanner dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
        .clr_addr(clr_addr), .clr_we(clr_we), .clr_data(clr_data),
        .sum(sum), .min_val(min_val), .max_val(max_val), .count(count)
    );

    always #5 clk = ~clk;

    // BRAM model: port A registered read, port B clear writes, plus an upstream write port.
    always @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (clr_we) mem[clr_addr] <= clr_data;
        if (wr_en)  mem[wr_addr]  <= wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Run one scan: model expected results, drive start, walk cycles checking
    // addresses, busy, done timing and results. repulse_at re-asserts start at cycle Tn.
    task automatic scan(input logic [9:0] base, input logic [10:0] len, input int repulse_at);
        exp_t e;
        int   s, v, mn, mx, exp_done;
        logic [9:0] a;
        s = 0; mn = 0; mx = 0;
        for (int k = 0; k < int'(len); k++) begin
            a = base + 10'(k);
            v = int'($signed(mem[a]));
            s += v;
            if (k == 0) begin mn = v; mx = v; end
            else begin
                if (v < mn) mn = v;
                if (v > mx) mx = v;
            end
            addr_q.push_back(a);
        end
        e.sum = 18'(s); e.mn = 8'(mn); e.mx = 8'(mx); e.cnt = len;
        exp_q.push_back(e);
        exp_done = (len == 0) ? 1 : int'(len) + 2;

        @(negedge clk);
        start = 1'b1; base_addr = base; length = len;
        for (int n = 1; n <= exp_done + 1; n++) begin
            @(negedge clk);
            start     = (n == repulse_at);
            base_addr = 10'd7;
            length    = 11'd3;
            if (n <= int'(len)) chk("rd_addr", 32'(rd_addr), 32'(addr_q.pop_front()));
            chk("busy", 32'(busy), 32'(n <= exp_done));
            chk("done_timing", 32'(done), 32'(n == exp_done));
            if (done === 1'b1) begin
                if (exp_q.size() == 0) chk("spurious_done", 32'(done), 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("sum", 32'(sum), 32'(e.sum));
                    chk("min_val", 32'(min_val), 32'(e.mn));
                    chk("max_val", 32'(max_val), 32'(e.mx));
                    chk("count", 32'(count), 32'(e.cnt));
                end
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        addr_q.delete();
        chk("hold_sum", 32'(sum), 32'(e.sum));
        chk("hold_count", 32'(count), 32'(e.cnt));
    endtask

    task automatic load_t1();
        wr(10'd0, 8'd1);
        wr(10'd1, 8'hFE);
        wr(10'd2, 8'd3);
        wr(10'd3, 8'hFC);
        wr(10'd4, 8'd55);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'd0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_clr_we", 32'(clr_we), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_clr_addr", 32'(clr_addr), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_min", 32'(min_val), 32'd0);
        chk("rst_max", 32'(max_val), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // test 1: small block from address 0
        load_t1();
        scan(10'd0, 11'd4, 0);
        chk("t1_sum_const", 32'(sum), 32'h3FFFE);
        chk("t1_min_const", 32'(min_val), 32'hFC);
        chk("t1_max_const", 32'(max_val), 32'd3);
`ifdef BRAM_SCAN_CLEAR_EN
        for (int i = 0; i < 4; i++) chk("clr_zeroed", 32'(mem[i]), 32'd0);
        chk("clr_untouched", 32'(mem[4]), 32'd55);
`else
        chk("mem0_kept", 32'(mem[0]), 32'd1);
        chk("mem3_kept", 32'(mem[3]), 32'hFC);
        chk("mem4_kept", 32'(mem[4]), 32'd55);
`endif

        // test 2: address wrap 1023 -> 0
        wr(10'd1022, 8'd10);
        wr(10'd1023, 8'd20);
        wr(10'd0, 8'd30);
        wr(10'd1, 8'hD8);
        scan(10'd1022, 11'd4, 0);
        chk("t2_sum_const", 32'(sum), 32'd20);

        // test 3: zero length
        scan(10'd5, 11'd0, 0);
        chk("t3_sum", 32'(sum), 32'd0);

        // test 4: full depth of -128
        for (int i = 0; i < 1024; i++) wr(10'(i), 8'h80);
        scan(10'd0, 11'd1024, 0);
        chk("t4_sum_const", 32'(sum), 32'h20000);
        chk("t4_min_const", 32'(min_val), 32'h80);

        // test 5: start re-pulsed mid-scan and on the done cycle is ignored
        load_t1();
        scan(10'd0, 11'd4, 2);
        load_t1();
        scan(10'd0, 11'd4, 6);
        chk("t5_sum_const", 32'(sum), 32'h3FFFE);

        // test 5b: reset during scan aborts with no done
        load_t1();
        @(negedge clk);
        start = 1'b1; base_addr = 10'd0; length = 11'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_count", 32'(count), 32'd0);
        chk("abort_clr_we", 32'(clr_we), 32'd0);
        rst = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_idle", 32'(busy), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
